// File: rtl/tag_match_scan.sv
// ---------------------------------------------------------------------------
// tag_match_scan
//
// Sequential tag store and searcher. Holds DEPTH 32-bit tags, each with a
// valid bit. A search request latches a key, and the block then walks the
// table one entry per cycle in ascending order. It reports hit/miss and the
// lowest matching index through a valid/ready response handshake. This is
// the cheap alternative to a full-parallel CAM.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset (aborts search, clears valids)
//   i_wr_en      write strobe for one entry
//   i_wr_idx     entry to write (values >= DEPTH are ignored)
//   i_wr_data    tag to store; the entry becomes valid
//   i_clr_all    clears every valid bit (wins over a same-cycle write)
//   i_req_valid  search request valid
//   o_req_ready  high in IDLE; request accepted on valid && ready
//   i_req_key    key to search, latched on acceptance
//   o_rsp_valid  response valid (RESP state)
//   i_rsp_ready  response consumed on valid && ready
//   o_rsp_hit    1 if a valid entry matched the key
//   o_rsp_idx    lowest matching index on a hit, 0 on a miss
//   o_busy       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module tag_match_scan #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic             i_clr_all,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [31:0]      i_req_key,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_hit,
  output logic [IDX_W-1:0] o_rsp_idx,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  // One extra bit so a non-power-of-two DEPTH can be range-checked.
  localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [31:0]      tag_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [31:0]      key_q, key_d;

  logic             wr_in_range;
  logic             match;

  assign wr_in_range = ({1'b0, i_wr_idx} < DEPTH_EXT);

  // XOR/NOR equality against the registered table, so a write at an edge
  // becomes visible to the comparison in the following cycle.
  assign match = valid_q[ptr_q] && ~|(tag_mem[ptr_q] ^ key_q);

  // Tag contents carry no reset; only the valid bits decide whether an
  // entry can match.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && wr_in_range) begin
      tag_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Clear has priority over a same-cycle write so nothing survives a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
    end else if (i_clr_all) begin
      valid_q <= '0;
    end else if (i_wr_en && wr_in_range) begin
      valid_q[i_wr_idx] <= 1'b1;
    end
  end

  // FSM state and search datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      key_q   <= key_d;
    end
  end

  // Next-state logic. The scan stops at the first match, which gives the
  // lowest matching index because the pointer only counts upward.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          key_d   = i_req_key;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          idx_d   = ptr_q;
          state_d = RESP;
        end else if (ptr_q == LAST_IDX) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = RESP;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_busy      = (state_q != IDLE);
  assign o_rsp_hit   = hit_q;
  assign o_rsp_idx   = idx_q;

endmodule

// File: tb/tb_tag_match_scan.sv
// ---------------------------------------------------------------------------
// tb_tag_match_scan
//
// Self-checking bench for tag_match_scan (DEPTH = 8). A table of
// {write, key, expected hit/idx/latency} records is applied in a loop,
// followed by hand-written sequences for mid-scan writes, backpressure,
// clear-versus-write, and reset during a scan.
// ---------------------------------------------------------------------------
module tb_tag_match_scan;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic             clr_all;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_key;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_idx;
  logic             busy;

  int total;
  int bad;

  tag_match_scan #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_wr_en     (wr_en),
    .i_wr_idx    (wr_idx),
    .i_wr_data   (wr_data),
    .i_clr_all   (clr_all),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_key   (req_key),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_hit   (rsp_hit),
    .o_rsp_idx   (rsp_idx),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  widx;
    logic [31:0] wdata;
    logic [31:0] key;
    logic        exp_hit;
    logic [2:0]  exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] data,
                               input logic clr);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    clr_all = clr;
    step();
    wr_en   = 1'b0;
    clr_all = 1'b0;
  endtask

  // Runs one search. Optionally drives a write while the scan is on cycle
  // wr_cycle (ptr == wr_cycle), and holds the response for 'hold' cycles
  // before consuming it. Latency counts edges from acceptance to rsp_valid.
  task automatic doSearch(input logic [31:0] key, input int wr_cycle,
                          input logic [2:0] widx, input logic [31:0] wdata,
                          input int hold, output int lat,
                          output logic hit, output logic [2:0] idx);
    int n;
    checkOutput("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_key   = key;
    step();
    req_valid = 1'b0;
    req_key   = ~key;
    checkOutput("busy_after_accept", {31'b0, busy}, 32'd1);
    checkOutput("req_ready_in_scan", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (n == wr_cycle) begin
        wr_en   = 1'b1;
        wr_idx  = widx;
        wr_data = wdata;
      end
      step();
      wr_en = 1'b0;
      n++;
    end
    lat = n;
    hit = rsp_hit;
    idx = rsp_idx;
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_hit", {31'b0, rsp_hit}, {31'b0, hit});
      checkOutput("bp_idx", {29'b0, rsp_idx}, {29'b0, idx});
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("post_rsp_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic hit;
    logic [2:0] idx;

    total = 0;
    bad   = 0;

    vecs[0] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'd0, 8};
    vecs[1] = '{1'b1, 3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'd5, 6};
    vecs[2] = '{1'b1, 3'd2, 32'h1234_5678, 32'h1234_5678, 1'b1, 3'd2, 3};
    vecs[3] = '{1'b1, 3'd6, 32'h1234_5678, 32'h1234_5678, 1'b1, 3'd2, 3};
    vecs[4] = '{1'b1, 3'd0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1, 3'd0, 1};
    vecs[5] = '{1'b1, 3'd7, 32'h0000_00FF, 32'h0000_00FE, 1'b0, 3'd0, 8};
    vecs[6] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0000_00FF, 1'b1, 3'd7, 8};
    vecs[7] = '{1'b1, 3'd5, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 3'd0, 8};

    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    clr_all   = 1'b0;
    req_valid = 1'b0;
    req_key   = '0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    $display("[TB] reset state");
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_hit", {31'b0, rsp_hit}, 32'd0);
    checkOutput("rst_rsp_idx", {29'b0, rsp_idx}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);

    $display("[TB] table vectors");
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) applyStimulus(vecs[v].widx, vecs[v].wdata, 1'b0);
      doSearch(vecs[v].key, -1, 3'd0, 32'h0, 0, lat, hit, idx);
      checkOutput($sformatf("vec%0d_hit", v), {31'b0, hit}, {31'b0, vecs[v].exp_hit});
      checkOutput($sformatf("vec%0d_idx", v), {29'b0, idx}, {29'b0, vecs[v].exp_idx});
      checkOutput($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
    end

    $display("[TB] clear wins over same-cycle write");
    applyStimulus(3'd0, 32'hCAFE_0001, 1'b1);
    doSearch(32'hCAFE_0001, -1, 3'd0, 32'h0, 0, lat, hit, idx);
    checkOutput("clr_hit", {31'b0, hit}, 32'd0);
    checkOutput("clr_idx", {29'b0, idx}, 32'd0);
    doSearch(32'h1234_5678, -1, 3'd0, 32'h0, 0, lat, hit, idx);
    checkOutput("clr_old_hit", {31'b0, hit}, 32'd0);

    $display("[TB] write ahead of pointer during scan");
    doSearch(32'hA5A5_A5A5, 3, 3'd7, 32'hA5A5_A5A5, 0, lat, hit, idx);
    checkOutput("ahead_hit", {31'b0, hit}, 32'd1);
    checkOutput("ahead_idx", {29'b0, idx}, 32'd7);
    checkOutput("ahead_lat", lat, 32'd8);

    $display("[TB] write behind pointer during scan");
    applyStimulus(3'd0, 32'h0, 1'b1);
    doSearch(32'hA5A5_A5A5, 3, 3'd1, 32'hA5A5_A5A5, 0, lat, hit, idx);
    checkOutput("behind_hit", {31'b0, hit}, 32'd0);
    checkOutput("behind_idx", {29'b0, idx}, 32'd0);
    checkOutput("behind_lat", lat, 32'd8);

    $display("[TB] backpressure");
    applyStimulus(3'd4, 32'hBEEF_0004, 1'b0);
    doSearch(32'hBEEF_0004, -1, 3'd0, 32'h0, 5, lat, hit, idx);
    checkOutput("bp_res_hit", {31'b0, hit}, 32'd1);
    checkOutput("bp_res_idx", {29'b0, idx}, 32'd4);
    checkOutput("bp_res_lat", lat, 32'd5);

    $display("[TB] reset during scan");
    req_valid = 1'b1;
    req_key   = 32'hBEEF_0004;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("midrst_quiet", {31'b0, rsp_valid}, 32'd0);
    end
    doSearch(32'hBEEF_0004, -1, 3'd0, 32'h0, 0, lat, hit, idx);
    checkOutput("midrst_tag4_hit", {31'b0, hit}, 32'd0);
    checkOutput("midrst_tag4_lat", lat, 32'd8);
    doSearch(32'hA5A5_A5A5, -1, 3'd0, 32'h0, 0, lat, hit, idx);
    checkOutput("midrst_tag1_hit", {31'b0, hit}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
